// File: rtl/sw_xor_array.sv
// Multi-channel debounced switch-pair XOR with per-channel LED modes,
// registered parity of all channel results and a saturating rising-edge counter.
module sw_xor_array #(
  parameter int unsigned CH        = 8,
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    a,
  input  logic [CH-1:0]    b,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic [CH-1:0]    led,
  output logic             parity,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam int unsigned N    = 2 * CH;
  localparam int unsigned DBW  = $clog2(DB_CYCLES);
  localparam int unsigned SUMW = CNT_W + $clog2(CH + 1);
  localparam logic [SUMW-1:0] CNT_MAX = {{(SUMW-CNT_W){1'b0}}, {CNT_W{1'b1}}};
  localparam logic [DBW-1:0]  DB_LAST = DBW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_LEVEL  = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_LATCH  = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  // Inputs a occupy the low CH bits, b the high CH bits.
  logic [N-1:0]     s1_q, s2_q, clean_q, clean_d;
  logic [DBW-1:0]   db_cnt_q [N];
  logic [DBW-1:0]   db_cnt_d [N];
  logic [CH-1:0]    x, xdly_q, rise;
  logic [CH-1:0]    t_q, t_d, led_q, led_d;
  mode_e            mode_in, mode_q;
  logic             parity_q;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [SUMW-1:0]  sum;

  assign mode_in = mode_e'(mode);
  assign x       = clean_q[CH-1:0] ^ clean_q[N-1:CH];
  assign rise    = x & ~xdly_q;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      clean_d[i]  = clean_q[i];
      db_cnt_d[i] = '0;
      if (s2_q[i] != clean_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) clean_d[i] = s2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // A mode change clears t in the same cycle the new mode drives the LEDs.
  always_comb begin
    t_d   = t_q;
    led_d = '0;
    if (clr || (mode_in != mode_q)) begin
      t_d = '0;
    end else begin
      case (mode_in)
        MODE_TOGGLE: t_d = t_q ^ rise;
        MODE_LATCH:  t_d = t_q | rise;
        default:     t_d = t_q;
      endcase
    end
    case (mode_in)
      MODE_LEVEL:              led_d = x;
      MODE_TOGGLE, MODE_LATCH: led_d = t_d;
      default:                 led_d = '0;
    endcase
  end

  // Sum is widened so the popcount of rises can never wrap before saturation.
  always_comb begin
    sum = SUMW'(edge_cnt_q);
    for (int unsigned i = 0; i < CH; i++) sum = sum + SUMW'(rise[i]);
    if (clr)                 edge_cnt_d = '0;
    else if (sum > CNT_MAX)  edge_cnt_d = '1;
    else                     edge_cnt_d = sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      clean_q    <= '0;
      xdly_q     <= '0;
      t_q        <= '0;
      led_q      <= '0;
      mode_q     <= MODE_LEVEL;
      parity_q   <= 1'b0;
      edge_cnt_q <= '0;
      for (int unsigned i = 0; i < N; i++) db_cnt_q[i] <= '0;
    end else begin
      s1_q       <= {b, a};
      s2_q       <= s1_q;
      clean_q    <= clean_d;
      xdly_q     <= x;
      t_q        <= t_d;
      led_q      <= led_d;
      mode_q     <= mode_in;
      parity_q   <= ^x;
      edge_cnt_q <= edge_cnt_d;
      for (int unsigned i = 0; i < N; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign led      = led_q;
  assign parity   = parity_q;
  assign edge_cnt = edge_cnt_q;

endmodule

// File: tb/tb_sw_xor_array.sv
// Directed self-checking bench for sw_xor_array (CH=8, DB_CYCLES=4, CNT_W=4).
module tb_sw_xor_array;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic [1:0] mode;
  logic       clr;
  logic [7:0] led;
  logic       parity;
  logic [3:0] edge_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sw_xor_array #(.CH(8), .DB_CYCLES(4), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .mode     (mode),
    .clr      (clr),
    .led      (led),
    .parity   (parity),
    .edge_cnt (edge_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; mode = 2'b00;
    a = 8'($urandom); b = 8'($urandom);
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (led !== 8'h00) begin $display("FAIL reset_led got=%h exp=00", led); errors++; end
    checks++; if (parity !== 1'b0) begin $display("FAIL reset_parity got=%b exp=0", parity); errors++; end
    checks++; if (edge_cnt !== 4'd0) begin $display("FAIL reset_edge_cnt got=%0d exp=0", edge_cnt); errors++; end
    a = 8'h00; b = 8'h00;
    repeat (10) tick();
    checks++; if (edge_cnt !== 4'd0) begin $display("FAIL reset_quiet_cnt got=%0d exp=0", edge_cnt); errors++; end
  endtask

  task automatic test_level();
    mode = 2'b00;
    a[0] = 1'b1;
    repeat (6) tick();
    checks++; if (led[0] !== 1'b0) begin $display("FAIL level_early got=%b exp=0", led[0]); errors++; end
    tick();
    checks++; if (led[0] !== 1'b1) begin $display("FAIL level_led0 got=%b exp=1", led[0]); errors++; end
    checks++; if (parity !== 1'b1) begin $display("FAIL level_parity got=%b exp=1", parity); errors++; end
    checks++; if (edge_cnt !== 4'd1) begin $display("FAIL level_cnt got=%0d exp=1", edge_cnt); errors++; end
    a[1] = 1'b1;
    repeat (3) tick();
    a[1] = 1'b0;
    repeat (10) tick();
    checks++; if (led !== 8'h01) begin $display("FAIL level_glitch_led got=%h exp=01", led); errors++; end
    checks++; if (edge_cnt !== 4'd1) begin $display("FAIL level_glitch_cnt got=%0d exp=1", edge_cnt); errors++; end
    a = 8'h00;
    settle();
    checks++; if (edge_cnt !== 4'd1) begin $display("FAIL level_fall_cnt got=%0d exp=1", edge_cnt); errors++; end
  endtask

  task automatic test_toggle_mode();
    mode = 2'b01; clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (edge_cnt !== 4'd0) begin $display("FAIL toggle_clr got=%0d exp=0", edge_cnt); errors++; end
    a[2] = 1'b1; settle();
    checks++; if (led[2] !== 1'b1) begin $display("FAIL toggle_rise1 got=%b exp=1", led[2]); errors++; end
    a[2] = 1'b0; settle();
    checks++; if (led[2] !== 1'b1) begin $display("FAIL toggle_fall1 got=%b exp=1", led[2]); errors++; end
    a[2] = 1'b1; settle();
    checks++; if (led[2] !== 1'b0) begin $display("FAIL toggle_rise2 got=%b exp=0", led[2]); errors++; end
    a[2] = 1'b0; settle();
    a[2] = 1'b1; settle();
    checks++; if (led[2] !== 1'b1) begin $display("FAIL toggle_rise3 got=%b exp=1", led[2]); errors++; end
    checks++; if (edge_cnt !== 4'd3) begin $display("FAIL toggle_cnt got=%0d exp=3", edge_cnt); errors++; end
    mode = 2'b10;
    tick();
    checks++; if (led[2] !== 1'b0) begin $display("FAIL latch_switch got=%b exp=0", led[2]); errors++; end
    a[2] = 1'b0; settle();
    checks++; if (led[2] !== 1'b0) begin $display("FAIL latch_idle got=%b exp=0", led[2]); errors++; end
    a[2] = 1'b1; settle();
    checks++; if (led[2] !== 1'b1) begin $display("FAIL latch_rise got=%b exp=1", led[2]); errors++; end
    a[2] = 1'b0; settle();
    checks++; if (led[2] !== 1'b1) begin $display("FAIL latch_hold got=%b exp=1", led[2]); errors++; end
    checks++; if (edge_cnt !== 4'd4) begin $display("FAIL latch_cnt got=%0d exp=4", edge_cnt); errors++; end
  endtask

  task automatic test_simultaneous();
    mode = 2'b00; clr = 1'b1;
    tick();
    clr = 1'b0;
    a = 8'hFF; b = 8'h00;
    repeat (6) tick();
    checks++; if (led !== 8'h00) begin $display("FAIL simul_early got=%h exp=00", led); errors++; end
    tick();
    checks++; if (led !== 8'hFF) begin $display("FAIL simul_led got=%h exp=ff", led); errors++; end
    checks++; if (edge_cnt !== 4'd8) begin $display("FAIL simul_cnt got=%0d exp=8", edge_cnt); errors++; end
    checks++; if (parity !== 1'b0) begin $display("FAIL simul_parity got=%b exp=0", parity); errors++; end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (edge_cnt !== 4'd0) begin $display("FAIL simul_clr got=%0d exp=0", edge_cnt); errors++; end
    a = 8'h00; settle();
    a[3] = 1'b1; b[3] = 1'b1; settle();
    checks++; if (led !== 8'h00) begin $display("FAIL pair_led got=%h exp=00", led); errors++; end
    checks++; if (edge_cnt !== 4'd0) begin $display("FAIL pair_cnt got=%0d exp=0", edge_cnt); errors++; end
    a[3] = 1'b0; b[3] = 1'b0; settle();
  endtask

  task automatic test_saturation();
    for (int n = 1; n <= 20; n++) begin
      a[0] = 1'b1; settle();
      if (n == 14) begin
        checks++; if (edge_cnt !== 4'd14) begin $display("FAIL sat_14 got=%0d exp=14", edge_cnt); errors++; end
      end
      if (n == 15) begin
        checks++; if (edge_cnt !== 4'd15) begin $display("FAIL sat_15 got=%0d exp=15", edge_cnt); errors++; end
      end
      a[0] = 1'b0; settle();
    end
    checks++; if (edge_cnt !== 4'd15) begin $display("FAIL sat_hold got=%0d exp=15", edge_cnt); errors++; end
    a[0] = 1'b1;
    repeat (6) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (edge_cnt !== 4'd0) begin $display("FAIL sat_clr_rise got=%0d exp=0", edge_cnt); errors++; end
    checks++; if (led[0] !== 1'b1) begin $display("FAIL sat_clr_led got=%b exp=1", led[0]); errors++; end
    tick();
    checks++; if (edge_cnt !== 4'd0) begin $display("FAIL sat_after_clr got=%0d exp=0", edge_cnt); errors++; end
  endtask

  task automatic test_off_and_reset();
    mode = 2'b11; clr = 1'b1;
    tick();
    clr = 1'b0;
    a[4] = 1'b1; settle();
    checks++; if (led !== 8'h00) begin $display("FAIL off_led got=%h exp=00", led); errors++; end
    checks++; if (edge_cnt !== 4'd1) begin $display("FAIL off_cnt got=%0d exp=1", edge_cnt); errors++; end
    a[5] = 1'b1;
    repeat (4) tick();
    rst = 1'b1; mode = 2'b00;
    tick();
    rst = 1'b0;
    checks++; if (led !== 8'h00) begin $display("FAIL rst_mid_led got=%h exp=00", led); errors++; end
    checks++; if (edge_cnt !== 4'd0) begin $display("FAIL rst_mid_cnt got=%0d exp=0", edge_cnt); errors++; end
    repeat (6) tick();
    checks++; if (led !== 8'h00) begin $display("FAIL restart_early got=%h exp=00", led); errors++; end
    tick();
    checks++; if (led !== 8'h31) begin $display("FAIL restart_led got=%h exp=31", led); errors++; end
    checks++; if (edge_cnt !== 4'd3) begin $display("FAIL restart_cnt got=%0d exp=3", edge_cnt); errors++; end
    checks++; if (parity !== 1'b1) begin $display("FAIL restart_parity got=%b exp=1", parity); errors++; end
  endtask

  initial begin
    test_reset();
    test_level();
    test_toggle_mode();
    test_simultaneous();
    test_saturation();
    test_off_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
